// File: rtl/px_burst_writer.sv
// Pixel FIFO plus REQ/GRANT + RDY/VLD burst writer for the pixel memory.
// Optional idle-flush timer: define PXWR_FLUSH_TIMEOUT_EN.
module px_burst_writer #(
    parameter int BURST_MAX  = 16,
    parameter int FIFO_DEPTH = 32,
    parameter int ADDR_W     = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] frame_base,
    input  logic              in_vld,
    output logic              in_rdy,
    input  logic [15:0]       in_data,
    input  logic              in_sof,
    input  logic              in_eof,
    output logic              wr_req,
    input  logic              wr_grant,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [3:0]        wr_burst,
    input  logic              wr_rdy,
    output logic              wr_vld,
    output logic [15:0]       wr_data,
    output logic              busy,
    output logic              frame_done
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] BMAX  = CW'(BURST_MAX);
    localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, BURST} state_t;

    state_t            state_q, state_d;
    logic [15:0]       mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        burst_q, burst_d;
    logic [3:0]        beats_q, beats_d;
    logic              eof_pend_q, eof_pend_d;

    logic          push, pop, sof_ok;
    logic          full_go, eof_go, tmo;
    logic [CW-1:0] len, len_m1;

    assign sof_ok = (state_q == IDLE) && (count_q == '0) && !eof_pend_q;
    assign in_rdy = (count_q < DEPTH) && (!in_sof || sof_ok);
    assign push   = in_vld && in_rdy;
    assign wr_vld = (state_q == BURST);
    assign wr_req = (state_q == REQ);
    assign pop    = wr_vld && wr_rdy;

    assign wr_addr  = addr_q;
    assign wr_burst = burst_q;
    assign wr_data  = (count_q != '0) ? mem_q[rd_ptr_q] : 16'h0000;
    assign busy     = (count_q != '0) || (state_q != IDLE);

    assign full_go = (count_q >= BMAX);
    assign eof_go  = eof_pend_q && (count_q != '0);
    assign len     = full_go ? BMAX : count_q;
    assign len_m1  = len - CW'(1);

`ifdef PXWR_FLUSH_TIMEOUT_EN
    logic [9:0] idle_q, idle_d;

    assign tmo = (idle_q == 10'h3ff) && (state_q == IDLE) && (count_q != '0);

    always_comb begin
        idle_d = '0;
        if (state_q == IDLE && count_q != '0 && count_q < BMAX && !push && !tmo)
            idle_d = idle_q + 10'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) idle_q <= '0;
        else        idle_q <= idle_d;
    end
`else
    assign tmo = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q + AW'(push);
        rd_ptr_d   = rd_ptr_q + AW'(pop);
        count_d    = count_q + CW'(push) - CW'(pop);
        cur_addr_d = cur_addr_q;
        addr_d     = addr_q;
        burst_d    = burst_q;
        beats_d    = beats_q;
        eof_pend_d = eof_pend_q;
        frame_done = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (full_go || eof_go || tmo) begin
                    state_d = REQ;
                    addr_d  = cur_addr_q;
                    burst_d = len_m1[3:0];
                    beats_d = len_m1[3:0];
                end else if (eof_pend_q && count_q == '0) begin
                    frame_done = 1'b1;
                    eof_pend_d = 1'b0;
                end
            end
            REQ: begin
                if (wr_grant) state_d = BURST;
            end
            BURST: begin
                if (pop) begin
                    if (beats_q == 4'd0) begin
                        state_d    = IDLE;
                        cur_addr_d = cur_addr_q + ADDR_W'(burst_q) + ADDR_W'(1);
                    end else begin
                        beats_d = beats_q - 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // SOF is only accepted when idle and drained, so it never races a burst end
        if (push && in_sof) cur_addr_d = frame_base;
        if (push && in_eof) eof_pend_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            cur_addr_q <= '0;
            addr_q     <= '0;
            burst_q    <= '0;
            beats_q    <= '0;
            eof_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            cur_addr_q <= cur_addr_d;
            addr_q     <= addr_d;
            burst_q    <= burst_d;
            beats_q    <= beats_d;
            eof_pend_q <= eof_pend_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_data;
    end

endmodule

// File: tb/tb_px_burst_writer.sv
// Randomized scoreboard bench for px_burst_writer; a frame-level model
// predicts bursts and beats, a monitor checks what the memory side sees.
module tb_px_burst_writer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [19:0] frame_base = '0;
    logic        in_vld = 1'b0;
    logic        in_rdy;
    logic [15:0] in_data = '0;
    logic        in_sof = 1'b0;
    logic        in_eof = 1'b0;
    logic        wr_req;
    logic        wr_grant = 1'b0;
    logic [19:0] wr_addr;
    logic [3:0]  wr_burst;
    logic        wr_rdy = 1'b1;
    logic        wr_vld;
    logic [15:0] wr_data;
    logic        busy;
    logic        frame_done;

    always #5 clk = ~clk;

    px_burst_writer dut (
        .clk(clk), .rst_n(rst_n), .frame_base(frame_base),
        .in_vld(in_vld), .in_rdy(in_rdy), .in_data(in_data),
        .in_sof(in_sof), .in_eof(in_eof),
        .wr_req(wr_req), .wr_grant(wr_grant), .wr_addr(wr_addr),
        .wr_burst(wr_burst), .wr_rdy(wr_rdy), .wr_vld(wr_vld),
        .wr_data(wr_data), .busy(busy), .frame_done(frame_done)
    );

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Reference model: bursts are cut every 16 pixels and at EOF
    typedef struct {
        logic [19:0] addr;
        logic [3:0]  len_m1;
    } burst_t;

    burst_t      exp_bq[$];
    logic [15:0] exp_dq[$];
    logic [15:0] m_pend[$];
    logic [19:0] m_addr = '0;
    int          exp_fd = 0;

    function automatic void m_flush();
        burst_t b;
        if (m_pend.size() == 0) return;
        b.addr   = m_addr;
        b.len_m1 = 4'(m_pend.size() - 1);
        exp_bq.push_back(b);
        foreach (m_pend[i]) exp_dq.push_back(m_pend[i]);
        m_addr = m_addr + 20'(m_pend.size());
        m_pend.delete();
    endfunction

    function automatic void m_accept(input logic [15:0] d, input bit sof,
                                     input bit eof, input logic [19:0] base);
        if (sof) m_addr = base;
        m_pend.push_back(d);
        if (m_pend.size() == 16) m_flush();
        if (eof) begin
            m_flush();
            exp_fd++;
        end
    endfunction

    // Memory model: grant and data-ready, driven just after each rising edge
    bit grant_en = 1'b1;
    bit fast_grant = 1'b1;
    int rdy_mode = 0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            wr_grant = grant_en && wr_req && (fast_grant || $urandom_range(0, 2) != 0);
            case (rdy_mode)
                0:       wr_rdy = 1'b1;
                1:       wr_rdy = ~wr_rdy;
                default: wr_rdy = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor
    int          beats_rem = 0;
    bit          just_g = 1'b0;
    int          fd_seen = 0;
    int          vld_err = 0;
    int          ovl_err = 0;
    burst_t      eb;

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (wr_req && wr_vld) ovl_err++;
                if (frame_done) fd_seen++;
                if (beats_rem > 0 && !just_g && !wr_vld) vld_err++;
                if (wr_vld && wr_rdy) begin
                    if (beats_rem == 0 || exp_dq.size() == 0) begin
                        n_tot++;
                        $display("FAIL unexpected_beat: got data %h expected none", wr_data);
                    end else begin
                        chk("wr_data", 32'(wr_data), 32'(exp_dq.pop_front()));
                        beats_rem--;
                    end
                end
                just_g = 1'b0;
                if (wr_req && wr_grant) begin
                    if (exp_bq.size() == 0) begin
                        n_tot++;
                        $display("FAIL unexpected_burst: got addr %h expected none", wr_addr);
                    end else begin
                        eb = exp_bq.pop_front();
                        chk("wr_addr", 32'(wr_addr), 32'(eb.addr));
                        chk("wr_burst", 32'(wr_burst), 32'(eb.len_m1));
                    end
                    beats_rem = int'(wr_burst) + 1;
                    just_g = 1'b1;
                end
            end
        end
    end

    task automatic send_pixel(input logic [15:0] d, input bit sof, input bit eof,
                              input logic [19:0] base);
        int n = 0;
        in_vld = 1'b1;
        in_data = d;
        in_sof = sof;
        in_eof = eof;
        frame_base = base;
        forever begin
            @(negedge clk);
            if (in_rdy) break;
            if (++n > 4000) begin
                n_tot++;
                $display("FAIL send_timeout: got in_rdy 0 expected 1");
                in_vld = 1'b0;
                in_sof = 1'b0;
                in_eof = 1'b0;
                return;
            end
        end
        if (sof) begin
            chk("sof_busy", 32'(busy), 32'd0);
            chk("sof_drained", 32'(exp_dq.size()), 32'd0);
        end
        m_accept(d, sof, eof, base);
        @(posedge clk);
        #1;
        in_vld = 1'b0;
        in_sof = 1'b0;
        in_eof = 1'b0;
    endtask

    task automatic send_frame(input int n, input bit sof, input bit eof_last,
                              input logic [19:0] base);
        for (int i = 0; i < n; i++)
            send_pixel(16'($urandom), sof && i == 0, eof_last && i == n - 1, base);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_dq.size() != 0 || exp_bq.size() != 0 || busy) begin
            @(negedge clk);
            if (++n > 5000) break;
        end
        chk("drain", 32'(exp_dq.size() + exp_bq.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [19:0] base;
        bit          saw;
        int          k;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr_req", 32'(wr_req), 32'd0);
        chk("rst_wr_vld", 32'(wr_vld), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_burst", 32'(wr_burst), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_in_rdy", 32'(in_rdy), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Pixels before any SOF go to address 0; check request latency
        send_frame(16, 1'b0, 1'b0, 20'h0);
        chk("req_latency_0", 32'(wr_req), 32'd0);
        @(posedge clk);
        #1;
        chk("req_latency_1", 32'(wr_req), 32'd1);
        wait_drain();

        // Two full bursts
        send_frame(32, 1'b1, 1'b0, 20'h00100);
        wait_drain();

        // EOF partial, then a new SOF that must stall behind it
        rdy_mode = 2;
        fast_grant = 1'b0;
        send_frame(20, 1'b1, 1'b1, 20'h00100);
        send_frame(10, 1'b1, 1'b1, 20'h02000);
        wait_drain();

        // Address wrap
        rdy_mode = 0;
        send_frame(16, 1'b1, 1'b0, 20'hFFFF8);
        send_frame(16, 1'b0, 1'b1, 20'hFFFF8);
        wait_drain();

        // FIFO fill with memory stalled, then toggling backpressure
        grant_en = 1'b0;
        send_frame(32, 1'b1, 1'b0, 20'h40000);
        in_vld = 1'b1;
        in_data = 16'h1234;
        @(negedge clk);
        chk("full_in_rdy", 32'(in_rdy), 32'd0);
        chk("full_busy", 32'(busy), 32'd1);
        in_vld = 1'b0;
        rdy_mode = 1;
        grant_en = 1'b1;
        @(posedge clk);
        #1;
        send_pixel(16'h1234, 1'b0, 1'b1, 20'h40000);
        wait_drain();

        // Idle partial burst
        rdy_mode = 0;
        send_frame(5, 1'b1, 1'b0, 20'h00300);
`ifdef PXWR_FLUSH_TIMEOUT_EN
        m_flush();
        k = 0;
        saw = 1'b0;
        while (k < 1100 && !saw) begin
            @(posedge clk);
            #1;
            k++;
            saw = wr_req;
        end
        chk("timeout_latency", 32'(k), 32'd1024);
        chk("timeout_burst", 32'(wr_burst), 32'd4);
`else
        saw = 1'b0;
        for (int i = 0; i < 1100; i++) begin
            @(negedge clk);
            if (wr_req) saw = 1'b1;
        end
        chk("no_timeout_req", 32'(saw), 32'd0);
        chk("no_timeout_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
`endif
        send_pixel(16'hBEEF, 1'b0, 1'b1, 20'h00300);
        wait_drain();

        // Random frames
        fast_grant = 1'b0;
        for (int f = 0; f < 6; f++) begin
            rdy_mode = $urandom_range(0, 2);
            base = 20'($urandom);
            send_frame($urandom_range(1, 40), 1'b1, 1'b1, base);
        end
        wait_drain();

        chk("frame_done_count", 32'(fd_seen), 32'(exp_fd));
        chk("req_vld_overlap", 32'(ovl_err), 32'd0);
        chk("vld_gap", 32'(vld_err), 32'd0);
        chk("beats_left", 32'(beats_rem), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/px_burst_writer.md
# px_burst_writer

Upstream write stage for the pixel memory. Accepts the decoder's 16-bit pixel stream through a valid/ready port and buffers it in an internal FIFO. Packs the pixels into write bursts of 1–16 beats. Runs the pixel memory's REQ/GRANT command phase and its RDY/VLD data phase, placing each frame contiguously from a programmable base address.

## Interface
Parameters:
- BURST_MAX, 16, beats per full burst (1..16).
- FIFO_DEPTH, 32, pixel FIFO entries (power of 2, ≥ BURST_MAX).
- ADDR_W, 20, pixel address width.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- frame_base  in  ADDR_W  first pixel address of a frame; sampled when an SOF pixel is accepted.
- in_vld  in  1  input pixel valid.
- in_rdy  out  1  input pixel ready.
- in_data  in  16  pixel.
- in_sof  in  1  qualifies the first pixel of a frame.
- in_eof  in  1  qualifies the last pixel of a frame.
- wr_req  out  1  write request to memory.
- wr_grant  in  1  memory grant.
- wr_addr  out  ADDR_W  burst start address.
- wr_burst  out  4  burst length minus 1.
- wr_rdy  in  1  memory ready for a data beat.
- wr_vld  out  1  data beat valid.
- wr_data  out  16  data beat.
- busy  out  1  FIFO non-empty, or state ≠ IDLE.
- frame_done  out  1  one-cycle pulse when the last pixel of a frame has been written.

## Operation
- FIFO:
  - Push on in_vld&in_rdy; pop on wr_vld&wr_rdy.
  - Simultaneous push and pop leaves the count unchanged.
  - in_rdy = (count < FIFO_DEPTH) and no SOF stall.
- SOF stall: in_rdy is held 0 for an SOF pixel until state = IDLE, the FIFO is empty and eof_pending = 0.
- SOF accept: on acceptance of the SOF pixel, cur_addr ← frame_base.
- EOF accept: on acceptance of an EOF pixel, eof_pending ← 1.
- Pixels arriving before the first SOF are written from cur_addr (reset value 0).
- State machine, three registered states:
  - IDLE → REQ when count ≥ BURST_MAX (len = BURST_MAX), or eof_pending&count>0 (len = min(count, BURST_MAX)), or a timeout flush (see Configuration).
    - On this transition: wr_addr ← cur_addr, wr_burst ← len−1, beats_left ← len−1.
  - REQ: wr_req=1; wr_addr and wr_burst are held stable. On wr_grant=1 → BURST. wr_req is 0 from the next cycle on.
  - BURST: wr_vld=1, wr_data = FIFO head. Each accepted beat decrements beats_left.
    - The beat accepted with beats_left=0 → IDLE and sets cur_addr ← cur_addr+len.
- Address arithmetic is modulo 2^ADDR_W; a burst that crosses the top of the address space wraps with no error.
- frame_done: pulses in the cycle after returning to IDLE when eof_pending=1 and count=0; eof_pending clears at the same time.
- The len pixels of a burst are in the FIFO before REQ is entered, so wr_vld never drops within a burst.
- Reset mid-burst: all state is discarded immediately and FIFO contents are lost. The memory side must be reset together with this block.

## Timing
- Reset values:
  - Outputs: wr_req=0, wr_vld=0, wr_addr=0, wr_burst=0, wr_data=0 (FIFO head after reset), in_rdy=1, busy=0, frame_done=0.
  - Internal: cur_addr=0, count=0, eof_pending=0, state=IDLE.
- Full-burst latency: wr_req rises one cycle after the clock edge that accepts the BURST_MAX-th buffered pixel.
- Grant to data: wr_vld rises the cycle after wr_grant is sampled. The memory's command cycle has wr_rdy=0, so the first beat transfers one cycle later.
- A BURST_MAX-beat burst with wr_rdy held high lasts BURST_MAX cycles of wr_vld.
- Minimum spacing between consecutive bursts: wr_req and wr_vld are never both 1.
  - Burst end → IDLE → REQ is 2 cycles, so wr_req is low for at least one cycle after the last beat.
  - This keeps the memory from re-entering write on a stale request.
- Input side: sustains one pixel per cycle while the FIFO has space.

## Configuration
- PXWR_FLUSH_TIMEOUT_EN defined:
  - A 10-bit idle counter increments while state=IDLE, 0<count<BURST_MAX and no push occurs.
  - The counter resets on any push or state change.
  - At 1023 the block forces IDLE→REQ with len=count, independent of EOF.
- PXWR_FLUSH_TIMEOUT_EN undefined: no counter; a partial burst is issued only on EOF.

## Test plan
- Full bursts: frame_base=0x00100, SOF + 32 pixels, no EOF, wr_grant one cycle after wr_req, wr_rdy=1 → two bursts, wr_addr=0x00100 then 0x00110, wr_burst=15; data in order.
- EOF partial: SOF + 20 pixels with EOF on the 20th → bursts of 16 and 4, wr_addr 0x00100/0x00110, wr_burst 15/3; frame_done pulses once after the final beat.
- Backpressure: wr_rdy toggling 1,0,1,0 during a burst → wr_vld stays 1; wr_data advances only on accepted beats; FIFO full drives in_rdy=0 at count=32.
- Wrap-around: frame_base=0xFFFF8, 16 pixels → one burst at 0xFFFF8; the next burst starts at 0x00008.
- SOF stall: new SOF arrives while the previous frame's last burst is in flight → in_rdy=0 until IDLE and the FIFO is empty; then cur_addr=new frame_base.
- Timeout (PXWR_FLUSH_TIMEOUT_EN): 5 pixels, then idle → wr_req rises 1024 cycles after the last push with wr_burst=4; without the macro, wr_req stays 0.
